// File: rtl/apu_pkg.sv
// ----------------------------------------------------------------------------
// apu_pkg
//   Shared constants for the APU pulse channel: widths, control-register bit
//   positions, envelope maximum and the length-counter load table.
// ----------------------------------------------------------------------------
package apu_pkg;

    localparam int VOL_W     = 4;
    localparam int LEN_W     = 8;
    localparam int LEN_IDX_W = 5;

    localparam logic [VOL_W-1:0] VOL_MAX = 4'd15;

    // Control register bit positions
    localparam int CTRL_HALT_BIT  = 5;   // length halt / envelope loop
    localparam int CTRL_CONST_BIT = 4;   // constant volume select

    // Length-counter load values, indexed by the 5-bit field of a length write
    localparam logic [LEN_W-1:0] LEN_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic [LEN_W-1:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage

// File: rtl/pulse_envelope.sv
// ----------------------------------------------------------------------------
// pulse_envelope
//   Envelope generator for the pulse channel. Holds the start flag, the
//   divider and the decay level; advances only on quarter-frame ticks.
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   quarter_tick  in   1-cycle envelope clock
//   start_set     in   length write seen: restart envelope on next tick
//   loop_flag     in   decay wraps 0 -> 15 when set
//   const_vol     in   select constant volume instead of decay
//   vol           in   constant volume / divider period
//   volume        out  current envelope volume
// ----------------------------------------------------------------------------
module pulse_envelope
    import apu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quarter_tick,
    input  logic             start_set,
    input  logic             loop_flag,
    input  logic             const_vol,
    input  logic [VOL_W-1:0] vol,
    output logic [VOL_W-1:0] volume
);

    logic             start;
    logic [VOL_W-1:0] divider;
    logic [VOL_W-1:0] decay;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge
    // values; blocking here would let later statements see updated state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start   <= 1'b0;
            divider <= '0;
            decay   <= '0;
        end else begin
            if (quarter_tick) begin
                if (start) begin
                    start   <= 1'b0;
                    decay   <= VOL_MAX;
                    divider <= vol;
                end else if (divider == '0) begin
                    divider <= vol;
                    if (decay != '0)
                        decay <= decay - VOL_W'(1);
                    else if (loop_flag)
                        decay <= VOL_MAX;
                end else begin
                    divider <= divider - VOL_W'(1);
                end
            end
            // A length write on a tick edge: the tick above consumed the old
            // start value; this later assignment leaves start set afterwards.
            if (start_set)
                start <= 1'b1;
        end
    end

    assign volume = const_vol ? vol : decay;

endmodule

// File: rtl/pulse_envelope_length.sv
// ----------------------------------------------------------------------------
// pulse_envelope_length
//   Pulse-channel stage after the duty sequencer: applies envelope volume and
//   the length-counter gate to the 1-bit duty waveform.
// Ports
//   clk             in   system clock
//   iReset          in   synchronous active-low reset
//   iQuarter_frame  in   envelope clock tick
//   iHalf_frame     in   length clock tick
//   iWr_ctrl        in   ctrl write: [5]=halt/loop [4]=const [3:0]=vol/period
//   iWr_length      in   length write: [7:3]=table index; restarts envelope
//   iWr_data        in   write data
//   iChannel_enable in   channel enable; low holds the length counter at 0
//   iPulse          in   duty waveform bit
//   oSample         out  registered channel sample
//   oActive         out  registered length != 0 status
// ----------------------------------------------------------------------------
module pulse_envelope_length
    import apu_pkg::*;
(
    input  logic             clk,
    input  logic             iReset,
    input  logic             iQuarter_frame,
    input  logic             iHalf_frame,
    input  logic             iWr_ctrl,
    input  logic             iWr_length,
    input  logic [7:0]       iWr_data,
    input  logic             iChannel_enable,
    input  logic             iPulse,
    output logic [VOL_W-1:0] oSample,
    output logic             oActive
);

    logic             halt;
    logic             const_vol;
    logic [VOL_W-1:0] vol;
    logic [LEN_W-1:0] length;
    logic [LEN_W-1:0] length_next;
    logic [VOL_W-1:0] volume;

    pulse_envelope u_envelope (
        .clk          (clk),
        .rst_n        (iReset),
        .quarter_tick (iQuarter_frame),
        .start_set    (iWr_length),
        .loop_flag    (halt),
        .const_vol    (const_vol),
        .vol          (vol),
        .volume       (volume)
    );

    // Disable beats a write, a write beats the half-frame decrement.
    // NOTE: default assigned first so every path drives length_next; a
    // missing branch would otherwise infer a latch.
    always_comb begin
        length_next = length;
        if (!iChannel_enable)
            length_next = '0;
        else if (iWr_length)
            length_next = len_lookup(iWr_data[7:3]);
        else if (iHalf_frame && !halt && length != '0)
            length_next = length - LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!iReset) begin
            halt      <= 1'b0;
            const_vol <= 1'b0;
            vol       <= '0;
            length    <= '0;
            oSample   <= '0;
            oActive   <= 1'b0;
        end else begin
            if (iWr_ctrl) begin
                halt      <= iWr_data[CTRL_HALT_BIT];
                const_vol <= iWr_data[CTRL_CONST_BIT];
                vol       <= iWr_data[VOL_W-1:0];
            end
            length  <= length_next;
            // Gate uses the pre-edge length; status reflects the new one.
            oSample <= (iPulse && length != '0) ? volume : '0;
            oActive <= (length_next != '0);
        end
    end

endmodule

// File: tb/tb_pulse_envelope_length.sv
// ----------------------------------------------------------------------------
// tb_pulse_envelope_length
//   Directed stimulus pushes hand-computed expected outputs into a queue;
//   a monitor on the falling edge pops and compares one entry per cycle.
// ----------------------------------------------------------------------------
module tb_pulse_envelope_length;

    logic       clk = 1'b0;
    logic       iReset = 1'b0;
    logic       iQuarter_frame = 1'b0;
    logic       iHalf_frame = 1'b0;
    logic       iWr_ctrl = 1'b0;
    logic       iWr_length = 1'b0;
    logic [7:0] iWr_data = 8'h00;
    logic       iChannel_enable = 1'b0;
    logic       iPulse = 1'b0;
    logic [3:0] oSample;
    logic       oActive;

    typedef struct {
        string      name;
        logic [3:0] sample;
        logic       active;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pulse_envelope_length dut (
        .clk             (clk),
        .iReset          (iReset),
        .iQuarter_frame  (iQuarter_frame),
        .iHalf_frame     (iHalf_frame),
        .iWr_ctrl        (iWr_ctrl),
        .iWr_length      (iWr_length),
        .iWr_data        (iWr_data),
        .iChannel_enable (iChannel_enable),
        .iPulse          (iPulse),
        .oSample         (oSample),
        .oActive         (oActive)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, ".sample"}, 8'(oSample), 8'(e.sample));
            check({e.name, ".active"}, 8'(oActive), 8'(e.active));
        end
    end

    task automatic expect_out(input string name, input logic [3:0] s, input logic a);
        exp_t e;
        e.name   = name;
        e.sample = s;
        e.active = a;
        sb.push_back(e);
    endtask

    // One clock; strobes are single-cycle
    task automatic step();
        @(posedge clk);
        #1;
        iWr_ctrl       = 1'b0;
        iWr_length     = 1'b0;
        iQuarter_frame = 1'b0;
        iHalf_frame    = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [7:0] d);
        iWr_ctrl = 1'b1;
        iWr_data = d;
        step();
    endtask

    task automatic wr_len(input logic [4:0] idx);
        iWr_length = 1'b1;
        iWr_data   = {idx, 3'b000};
        step();
    endtask

    task automatic qtick();
        iQuarter_frame = 1'b1;
        step();
    endtask

    task automatic htick();
        iHalf_frame = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset; writes and ticks during reset must be ignored
        iChannel_enable = 1'b1;
        iPulse          = 1'b1;
        step();
        step();
        iWr_length     = 1'b1;
        iWr_data       = {5'd1, 3'b000};
        iQuarter_frame = 1'b1;
        step();
        expect_out("reset", 4'd0, 1'b0);
        iReset = 1'b1;

        // 1: constant volume 15, length idx 1 (254)
        wr_ctrl(8'h3F);
        wr_len(5'd1);
        expect_out("t1_write", 4'd0, 1'b1);
        step();
        expect_out("t1_const15", 4'd15, 1'b1);

        // 2: decay mode, period 0: one step per quarter tick, holds at 0
        wr_ctrl(8'h00);
        wr_len(5'd1);
        qtick();
        step();
        expect_out("t2_start", 4'd15, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            qtick();
            step();
            expect_out($sformatf("t2_decay%0d", k), (k >= 15) ? 4'd0 : 4'(15 - k), 1'b1);
        end

        // 3: loop, period 1: one step per two ticks, wraps 0 -> 15
        wr_ctrl(8'h21);
        wr_len(5'd1);
        qtick();
        step();
        expect_out("t3_start", 4'd15, 1'b1);
        for (int t = 1; t <= 32; t++) begin
            qtick();
            step();
            expect_out($sformatf("t3_loop%0d", t), (t == 32) ? 4'd15 : 4'(15 - t / 2), 1'b1);
        end
        iPulse = 1'b0;
        step();
        expect_out("t3_pulse_low", 4'd0, 1'b1);
        iPulse = 1'b1;

        // 4: length 2 runs out after two half ticks
        wr_ctrl(8'h1F);
        wr_len(5'd3);
        step();
        expect_out("t4_len2", 4'd15, 1'b1);
        htick();
        expect_out("t4_half1", 4'd15, 1'b1);
        htick();
        expect_out("t4_half2", 4'd15, 1'b0);
        step();
        expect_out("t4_expired", 4'd0, 1'b0);

        // 5: write on a half tick loads 10 (not 9); 10 ticks to expire
        iWr_length  = 1'b1;
        iHalf_frame = 1'b1;
        iWr_data    = {5'd0, 3'b000};
        step();
        expect_out("t5_wr_on_half", 4'd0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            htick();
            expect_out($sformatf("t5_count%0d", i), 4'd15, (i < 10));
        end
        iChannel_enable = 1'b0;
        wr_len(5'd1);
        expect_out("t5_disabled_wr", 4'd0, 1'b0);
        step();
        expect_out("t5_disabled_hold", 4'd0, 1'b0);
        iChannel_enable = 1'b1;
        wr_len(5'd1);
        expect_out("t5_reenable", 4'd0, 1'b1);
        iChannel_enable = 1'b0;
        step();
        expect_out("t5_disable_clears", 4'd15, 1'b0);
        step();
        expect_out("t5_disabled_out", 4'd0, 1'b0);
        iChannel_enable = 1'b1;

        // 6: reset mid-decay with length 80
        wr_ctrl(8'h00);
        wr_len(5'd6);
        qtick();
        qtick();
        step();
        expect_out("t6_mid_decay", 4'd14, 1'b1);
        iReset         = 1'b0;
        iQuarter_frame = 1'b1;
        step();
        expect_out("t6_reset", 4'd0, 1'b0);
        iReset = 1'b1;
        qtick();
        qtick();
        expect_out("t6_no_restart", 4'd0, 1'b0);
        wr_len(5'd6);
        expect_out("t6_rewrite", 4'd0, 1'b1);
        step();
        expect_out("t6_decay_held", 4'd0, 1'b1);
        qtick();
        step();
        expect_out("t6_restart", 4'd15, 1'b1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
